// File: rtl/wb_pkg.sv
// Writeback unit shared types and widths.
// Entry layout carried through the writeback queue.
package wb_pkg;

  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular writeback queue: two enqueue ports, one dequeue port.
// Head pops every cycle it holds an entry; register file never stalls.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push_a,
  input  wb_entry_t                        data_a,
  input  logic                             push_b,
  input  wb_entry_t                        data_b,
  output wb_entry_t                        head_entry,
  output logic [CW-1:0]                    count,
  output logic [DEPTH-1:0]                 valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] rds
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] tail_b;
  logic          pop;

  assign pop = (count != '0);
  assign tail_b = tail + AW'(push_a);
  assign head_entry = mem[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop)
        head <= head + AW'(1);
      tail  <= tail + AW'(push_a) + AW'(push_b);
      count <= count + CW'(push_a)
             + CW'(push_b) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_a)
      mem[tail] <= data_a;
    if (push_b)
      mem[tail_b] <= data_b;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      logic [AW-1:0] off;
      off = AW'(i) - head;
      valid[i] = (int'(off) < int'(count));
      rds[i] = mem[i].rd;
    end
  end

  a_no_overflow : assert property (
    @(posedge clk) disable iff (rst)
    count <= CW'(DEPTH)
  );

endmodule

// File: rtl/writeback_unit.sv
// Merges ALU and load results into one register-file write per cycle.
// ALU is queued ahead of MEM when both arrive; x0 targets are dropped.
module writeback_unit #(
  parameter int XLEN = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [REG_ADDR_W-1:0]        alu_rd,
  input  logic [XLEN-1:0]              alu_data,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [REG_ADDR_W-1:0]        mem_rd,
  input  logic [XLEN-1:0]              mem_data,
  output logic [REG_ADDR_W-1:0]        rf_write_reg,
  output logic [XLEN-1:0]              rf_write_data,
  output logic                         rf_read_write,
  output logic [31:0]                  pending_mask,
  output logic [$clog2(DEPTH+1)-1:0]   wb_count
);

  import wb_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]                    count;
  logic [CW:0]                      free;
  logic                             alu_nz;
  logic                             mem_nz;
  logic                             enq_alu;
  logic                             enq_mem;
  wb_entry_t                        alu_e;
  wb_entry_t                        mem_e;
  wb_entry_t                        head_e;
  logic [DEPTH-1:0]                 valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] rds;

  // The head drains this cycle, so its slot counts as free.
  assign free = (CW+1)'(DEPTH) - (CW+1)'(count)
              + (CW+1)'(count != '0);

  assign alu_nz = (alu_rd != '0);
  assign mem_nz = (mem_rd != '0);

  assign alu_ready = ~rst & (free >= (CW+1)'(1));
  assign mem_ready = ~rst
    & ((free >= (CW+1)'(2))
       | ~(alu_valid & alu_nz));

  assign enq_alu = alu_valid & alu_ready & alu_nz;
  assign enq_mem = mem_valid & mem_ready & mem_nz;

  assign alu_e = '{rd: alu_rd, data: alu_data};
  assign mem_e = '{rd: mem_rd, data: mem_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_a     (enq_alu | enq_mem),
    .data_a     (enq_alu ? alu_e : mem_e),
    .push_b     (enq_alu & enq_mem),
    .data_b     (mem_e),
    .head_entry (head_e),
    .count      (count),
    .valid      (valid),
    .rds        (rds)
  );

  assign rf_read_write = ~rst & (count != '0);
  assign rf_write_reg  = head_e.rd;
  assign rf_write_data = head_e.data;
  assign wb_count      = count;

  always_comb begin
    logic [NUM_REGS-1:0] m;
    m = '0;
    for (int i = 0; i < DEPTH; i++)
      if (valid[i])
        m[rds[i]] = 1'b1;
    m[0] = 1'b0;
    pending_mask = m;
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Scenario bench for writeback_unit.
// A negedge scoreboard tracks every queued write against rf_* output.
module tb_writeback_unit;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_data = '0;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic        rf_read_write;
  logic [31:0] pending_mask;
  logic [2:0]  wb_count;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  exp_t sb[$];
  logic [31:0] rf_model [32];

  always #5 clk = ~clk;

  writeback_unit #(.XLEN(32), .REG_ADDR_W(5), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_rd        (mem_rd),
    .mem_data      (mem_data),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .rf_read_write (rf_read_write),
    .pending_mask  (pending_mask),
    .wb_count      (wb_count)
  );

  // Reference model: queue contents, readies, mask and commit order.
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if ({rf_read_write, alu_ready, mem_ready} !== 3'b000) begin
        errors++;
        $display("FAIL sb_rst rw/ar/mr=%b%b%b want 000",
                 rf_read_write, alu_ready, mem_ready);
      end
      sb.delete();
    end else begin
      int sz;
      int fr;
      logic [31:0] em;
      logic ea;
      logic emr;
      exp_t e;
      sz = sb.size();
      fr = DEPTH - sz + ((sz != 0) ? 1 : 0);
      em = '0;
      foreach (sb[k]) em[sb[k].rd] = 1'b1;
      em[0] = 1'b0;
      ea = (fr >= 1);
      emr = (fr >= 2) || !(alu_valid && alu_rd != 0);
      checks++;
      if (wb_count !== 3'(sz)) begin
        errors++;
        $display("FAIL sb_count got %0d want %0d", wb_count, sz);
      end
      checks++;
      if (rf_read_write !== (sz != 0)) begin
        errors++;
        $display("FAIL sb_rw got %b want %b", rf_read_write, sz != 0);
      end
      checks++;
      if (pending_mask !== em) begin
        errors++;
        $display("FAIL sb_mask got %h want %h", pending_mask, em);
      end
      checks++;
      if (alu_ready !== ea || mem_ready !== emr) begin
        errors++;
        $display("FAIL sb_ready got %b%b want %b%b",
                 alu_ready, mem_ready, ea, emr);
      end
      if (sz != 0) begin
        e = sb.pop_front();
        checks++;
        if (rf_write_reg !== e.rd || rf_write_data !== e.data) begin
          errors++;
          $display("FAIL sb_write got x%0d=%h want x%0d=%h",
                   rf_write_reg, rf_write_data, e.rd, e.data);
        end
      end
      if (rf_read_write === 1'b1) begin
        wr_cnt++;
        rf_model[rf_write_reg] = rf_write_data;
      end
      if (alu_valid && alu_ready && alu_rd != 0)
        sb.push_back('{rd: alu_rd, data: alu_data});
      if (mem_valid && mem_ready && mem_rd != 0)
        sb.push_back('{rd: mem_rd, data: mem_data});
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got %b%b want 00",
               alu_ready, mem_ready);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_count !== 3'd0 || pending_mask !== 32'h0
        || rf_read_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_state cnt=%0d mask=%h rw=%b want 0/0/0",
               wb_count, pending_mask, rf_read_write);
    end
    next_cycle();
  endtask

  task automatic test_single();
    alu_valid = 1'b1;
    alu_rd = 5'd5;
    alu_data = 32'hDEADBEEF;
    next_cycle();
    alu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rf_read_write !== 1'b1 || rf_write_reg !== 5'd5
        || rf_write_data !== 32'hDEADBEEF
        || pending_mask !== 32'h20) begin
      errors++;
      $display("FAIL single_n1 rw=%b x%0d=%h mask=%h want 1 x5=deadbeef 20",
               rf_read_write, rf_write_reg, rf_write_data, pending_mask);
    end
    @(negedge clk);
    checks++;
    if (rf_read_write !== 1'b0 || pending_mask !== 32'h0) begin
      errors++;
      $display("FAIL single_n2 rw=%b mask=%h want 0 0",
               rf_read_write, pending_mask);
    end
    next_cycle();
  endtask

  task automatic test_same_rd();
    alu_valid = 1'b1;
    alu_rd = 5'd3;
    alu_data = 32'h11;
    mem_valid = 1'b1;
    mem_rd = 5'd3;
    mem_data = 32'h22;
    next_cycle();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rf_write_reg !== 5'd3 || rf_write_data !== 32'h11
        || wb_count !== 3'd2) begin
      errors++;
      $display("FAIL same_rd_n1 x%0d=%h cnt=%0d want x3=11 2",
               rf_write_reg, rf_write_data, wb_count);
    end
    @(negedge clk);
    checks++;
    if (rf_read_write !== 1'b1 || rf_write_data !== 32'h22) begin
      errors++;
      $display("FAIL same_rd_n2 rw=%b data=%h want 1 22",
               rf_read_write, rf_write_data);
    end
    @(negedge clk);
    checks++;
    if (rf_model[3] !== 32'h22 || rf_read_write !== 1'b0) begin
      errors++;
      $display("FAIL same_rd_final x3=%h rw=%b want 22 0",
               rf_model[3], rf_read_write);
    end
    next_cycle();
  endtask

  task automatic test_x0();
    int w0;
    w0 = wr_cnt;
    alu_valid = 1'b1;
    alu_rd = 5'd0;
    alu_data = 32'h1234;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (alu_ready !== 1'b1 || wb_count !== 3'd0
          || rf_read_write !== 1'b0) begin
        errors++;
        $display("FAIL x0 ar=%b cnt=%0d rw=%b want 1 0 0",
                 alu_ready, wb_count, rf_read_write);
      end
      next_cycle();
    end
    alu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_cnt != w0 || rf_read_write !== 1'b0) begin
      errors++;
      $display("FAIL x0_writes got %0d want 0", wr_cnt - w0);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    int ai = 0;
    int mi = 0;
    int maxc = 0;
    int w0;
    bit stall = 0;
    bit acc_a;
    bit acc_m;
    w0 = wr_cnt;
    for (int c = 0; c < 40 && (ai < 8 || mi < 8); c++) begin
      alu_valid = (ai < 8);
      alu_rd = 5'(1 + ai);
      alu_data = 32'hA000_0000 + 32'(ai);
      mem_valid = (mi < 8);
      mem_rd = 5'(9 + mi);
      mem_data = 32'hB000_0000 + 32'(mi);
      @(negedge clk);
      if (int'(wb_count) > maxc) maxc = int'(wb_count);
      if (mem_valid && !mem_ready) stall = 1;
      acc_a = alu_valid && alu_ready;
      acc_m = mem_valid && mem_ready;
      next_cycle();
      if (acc_a) ai++;
      if (acc_m) mi++;
    end
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    checks++;
    if (ai != 8 || mi != 8) begin
      errors++;
      $display("FAIL b2b_accept got %0d/%0d want 8/8", ai, mi);
    end
    checks++;
    if (maxc != DEPTH || !stall) begin
      errors++;
      $display("FAIL b2b_full maxcnt=%0d stall=%0d want %0d 1",
               maxc, stall, DEPTH);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (wb_count == 3'd0) break;
    end
    checks++;
    if (wb_count !== 3'd0 || wr_cnt - w0 != 16) begin
      errors++;
      $display("FAIL b2b_drain cnt=%0d writes=%0d want 0 16",
               wb_count, wr_cnt - w0);
    end
    next_cycle();
  endtask

  task automatic test_mid_reset();
    alu_valid = 1'b1;
    alu_rd = 5'd20;
    alu_data = 32'h20;
    mem_valid = 1'b1;
    mem_rd = 5'd21;
    mem_data = 32'h21;
    next_cycle();
    alu_rd = 5'd22;
    alu_data = 32'h22;
    mem_rd = 5'd23;
    mem_data = 32'h23;
    next_cycle();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (wb_count !== 3'd3 || alu_ready !== 1'b0
        || mem_ready !== 1'b0 || rf_read_write !== 1'b0) begin
      errors++;
      $display("FAIL midrst_hold cnt=%0d ar=%b mr=%b rw=%b want 3 0 0 0",
               wb_count, alu_ready, mem_ready, rf_read_write);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_count !== 3'd0 || rf_read_write !== 1'b0
        || pending_mask !== 32'h0) begin
      errors++;
      $display("FAIL midrst_after cnt=%0d rw=%b mask=%h want 0 0 0",
               wb_count, rf_read_write, pending_mask);
    end
    next_cycle();
  endtask

  task automatic test_idle();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (rf_read_write !== 1'b0 || alu_ready !== 1'b1
          || mem_ready !== 1'b1 || wb_count !== 3'd0) begin
        errors++;
        $display("FAIL idle rw=%b ar=%b mr=%b cnt=%0d want 0 1 1 0",
                 rf_read_write, alu_ready, mem_ready, wb_count);
      end
      next_cycle();
    end
  endtask

  initial begin
    foreach (rf_model[k]) rf_model[k] = '0;
    test_reset();
    test_single();
    test_same_rd();
    test_x0();
    test_back_to_back();
    test_mid_reset();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
